// File: rtl/adder_vector_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : adder_vector_gen_if
// Description : Valid/ready vector stream from the adder stimulus generator
//               to its consumer (self-checking harness or BIST comparator).
//   vec_valid  gen -> cons  vec_data/vec_idx/vec_last are valid
//   vec_ready  cons -> gen  consumer takes the vector this cycle
//   vec_data   gen -> cons  {x[W-1:0], y[W-1:0], s[W:0]}
//   vec_idx    gen -> cons  sequence number of the current vector
//   vec_last   gen -> cons  final vector of the sweep
//   Modports: master (generator side), slave (consumer side)
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_vector_gen_if #(
  parameter int WIDTH = 6
);
  logic                 vec_valid;
  logic                 vec_ready;
  logic [3*WIDTH:0]     vec_data;
  logic [2*WIDTH-1:0]   vec_idx;
  logic                 vec_last;

  modport master (
    output vec_valid,
    output vec_data,
    output vec_idx,
    output vec_last,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec_data,
    input  vec_idx,
    input  vec_last,
    output vec_ready
  );
endinterface
`default_nettype wire

// File: rtl/adder_vector_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : adder_vector_gen
// Description : Stimulus source for the adder flow. Enumerates every (x,y)
//               operand pair, computes the golden sum s = x + y (carry kept)
//               and streams {x,y,s} over a valid/ready interface.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a full sweep (only honoured in IDLE)
//   vec    if   master side of adder_vector_gen_if (valid/ready stream)
//   busy   out  high while a sweep is running
//   done   out  one-cycle pulse after the final transfer
// Config macro: ADDER_VECGEN_LFSR_EN - emit operand pairs in pseudo-random
//               order from a 12-bit Fibonacci LFSR (WIDTH must be 6).
//               Undefined: sequential order, no LFSR logic.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_vector_gen #(
  parameter int WIDTH = 6
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  adder_vector_gen_if.master     vec,
  output logic                   busy,
  output logic                   done
);

  localparam int c_nw = 2 * WIDTH;      // ord / index width
  localparam int c_dw = 3 * WIDTH + 1;  // vector width

  localparam logic [c_nw-1:0] c_idx_max  = '1;
  localparam logic [c_nw-1:0] c_ord_zero = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_valid;
  logic [c_dw-1:0]   r_data;
  logic [c_nw-1:0]   r_idx;
  logic              r_last;
  logic              r_busy;
  logic              r_done;

  logic              w_xfer;
  logic [c_nw-1:0]   w_idx_next;
  logic [c_nw-1:0]   w_ord_next;

  // Build {x, y, s} from an ordinal: upper half is x, lower half is y.
  function automatic logic [c_dw-1:0] f_make_vec(input logic [c_nw-1:0] ord);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   s;
    x = ord[c_nw-1:WIDTH];
    y = ord[WIDTH-1:0];
    s = {1'b0, x} + {1'b0, y};
    return {x, y, s};
  endfunction

  assign w_xfer     = r_valid & vec.vec_ready;
  assign w_idx_next = r_idx + 1'b1;

`ifdef ADDER_VECGEN_LFSR_EN
  if (WIDTH != 6) begin : g_lfsr_width_check
    $error("adder_vector_gen: LFSR ordering requires WIDTH == 6");
  end

  localparam logic [c_nw-1:0] c_lfsr_seed = {{(c_nw-1){1'b0}}, 1'b1};

  // r_lfsr holds the ord of the *next* vector; idx 0 is always ord 0, then
  // the LFSR walks all 4095 non-zero states, one step per transfer.
  logic [c_nw-1:0] r_lfsr;
  logic [c_nw-1:0] w_lfsr_step;

  assign w_lfsr_step = {r_lfsr[c_nw-2:0], r_lfsr[11] ^ r_lfsr[5] ^ r_lfsr[3] ^ r_lfsr[0]};
  assign w_ord_next  = r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_lfsr <= c_lfsr_seed;
    end else if (r_state == S_RUN && w_xfer && !r_last) begin
      r_lfsr <= w_lfsr_step;
    end
  end
`else
  assign w_ord_next = w_idx_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_data  <= f_make_vec(c_ord_zero);
            r_last  <= 1'b0;
          end
        end
        S_RUN: begin
          // Outputs only move on a transfer, which gives stable data under
          // backpressure for free.
          if (w_xfer) begin
            if (r_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_idx   <= '0;
              r_data  <= '0;
            end else begin
              r_idx  <= w_idx_next;
              r_data <= f_make_vec(w_ord_next);
              r_last <= (w_idx_next == c_idx_max);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign vec.vec_valid = r_valid;
  assign vec.vec_data  = r_data;
  assign vec.vec_idx   = r_idx;
  assign vec.vec_last  = r_last;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
`default_nettype wire
